// File: rtl/trap_sequencer.sv
// Trap/CSR write-side sequencer for Reg_Stack: Zicsr read-modify-write, ECALL entry and MRET.
// Optional trap counter output enabled by defining TRAP_SEQ_CNT_EN.
module trap_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ECALL_CODE = 11
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [1:0]      wb_op,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [11:0]     wb_csr_addr,
  input  logic [1:0]      wb_csr_fn,
  input  logic [XLEN-1:0] wb_csr_src,
  input  logic [XLEN-1:0] csrs,
  input  logic [XLEN-1:0] mepc_in,
  input  logic [XLEN-1:0] mtvec_in,
  output logic [XLEN-1:0] csr_addr,
  output logic [3:0]      csr_wen,
  output logic [XLEN-1:0] csrd,
  output logic            ecall_flag,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] csr_old,
  output logic            csr_old_vld,
  output logic            redirect_vld,
  output logic [XLEN-1:0] redirect_pc,
`ifdef TRAP_SEQ_CNT_EN
  output logic [XLEN-1:0] trap_cnt,
`endif
  output logic            busy
);

  typedef enum logic [2:0] {StIdle, StCRd, StCWr, StTSave, StTJmp, StMJmp} state_e;

  localparam logic [1:0] OpCsr   = 2'd0;
  localparam logic [1:0] OpEcall = 2'd1;
  localparam logic [1:0] OpMret  = 2'd2;
  localparam logic [1:0] FnRw    = 2'd1;
  localparam logic [1:0] FnRc    = 2'd3;

  state_e            state_q, state_d;
  logic [1:0]        fn_q, fn_d;
  logic [XLEN-1:0]   src_q, src_d;
  logic [11:0]       addr_q, addr_d;
  logic [XLEN-1:0]   csr_addr_q, csr_addr_d;
  logic [3:0]        csr_wen_q, csr_wen_d;
  logic [XLEN-1:0]   csrd_q, csrd_d;
  logic              ecall_flag_q, ecall_flag_d;
  logic [XLEN-1:0]   trap_pc_q, trap_pc_d;
  logic [XLEN-1:0]   csr_old_q, csr_old_d;
  logic              csr_old_vld_q, csr_old_vld_d;
  logic              redirect_vld_q, redirect_vld_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              accept;
  logic [XLEN-1:0]   eff_src;
  logic [3:0]        wen_dec;
  logic              write_ok;

  assign accept = wb_valid && (state_q == StIdle);

  // Reserved fn 0 behaves as RS with a zero source: a pure read.
  assign eff_src  = (fn_q == 2'd0) ? '0 : src_q;
  assign write_ok = (fn_q == FnRw) || (eff_src != '0);

  always_comb begin
    wen_dec = 4'b0000;
    case (addr_q)
      12'h341: wen_dec = 4'b0001;
      12'h342: wen_dec = 4'b0010;
      12'h300: wen_dec = 4'b0100;
      12'h305: wen_dec = 4'b1000;
      default: wen_dec = 4'b0000;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    fn_d           = fn_q;
    src_d          = src_q;
    addr_d         = addr_q;
    csr_addr_d     = '0;
    csr_wen_d      = '0;
    csrd_d         = '0;
    ecall_flag_d   = 1'b0;
    trap_pc_d      = '0;
    csr_old_d      = '0;
    csr_old_vld_d  = 1'b0;
    redirect_vld_d = 1'b0;
    redirect_pc_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          fn_d   = wb_csr_fn;
          src_d  = wb_csr_src;
          addr_d = wb_csr_addr;
          case (wb_op)
            OpCsr: begin
              state_d    = StCRd;
              csr_addr_d = {{(XLEN-12){1'b0}}, wb_csr_addr};
            end
            OpEcall: begin
              state_d      = StTSave;
              ecall_flag_d = 1'b1;
              trap_pc_d    = wb_pc;
              csr_wen_d    = 4'b0010;
              csrd_d       = XLEN'(ECALL_CODE);
            end
            OpMret: begin
              state_d        = StMJmp;
              redirect_vld_d = 1'b1;
              redirect_pc_d  = mepc_in;
            end
            default: ;
          endcase
        end
      end
      StCRd: begin
        state_d       = StCWr;
        csr_addr_d    = csr_addr_q;
        csr_old_d     = csrs;
        csr_old_vld_d = 1'b1;
        if (fn_q == FnRw)      csrd_d = src_q;
        else if (fn_q == FnRc) csrd_d = csrs & ~src_q;
        else                   csrd_d = csrs | eff_src;
        csr_wen_d = write_ok ? wen_dec : 4'b0000;
      end
      StTSave: begin
        state_d        = StTJmp;
        redirect_vld_d = 1'b1;
        redirect_pc_d  = mtvec_in & ~XLEN'(3);
      end
      StCWr, StTJmp, StMJmp: state_d = StIdle;
      default:               state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      fn_q           <= '0;
      src_q          <= '0;
      addr_q         <= '0;
      csr_addr_q     <= '0;
      csr_wen_q      <= '0;
      csrd_q         <= '0;
      ecall_flag_q   <= 1'b0;
      trap_pc_q      <= '0;
      csr_old_q      <= '0;
      csr_old_vld_q  <= 1'b0;
      redirect_vld_q <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      state_q        <= state_d;
      fn_q           <= fn_d;
      src_q          <= src_d;
      addr_q         <= addr_d;
      csr_addr_q     <= csr_addr_d;
      csr_wen_q      <= csr_wen_d;
      csrd_q         <= csrd_d;
      ecall_flag_q   <= ecall_flag_d;
      trap_pc_q      <= trap_pc_d;
      csr_old_q      <= csr_old_d;
      csr_old_vld_q  <= csr_old_vld_d;
      redirect_vld_q <= redirect_vld_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

`ifdef TRAP_SEQ_CNT_EN
  logic [XLEN-1:0] cnt_q, cnt_d;

  assign cnt_d = (accept && (wb_op == OpEcall)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign trap_cnt = cnt_q;
`endif

  assign wb_ready     = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign csr_addr     = csr_addr_q;
  assign csr_wen      = csr_wen_q;
  assign csrd         = csrd_q;
  assign ecall_flag   = ecall_flag_q;
  assign trap_pc      = trap_pc_q;
  assign csr_old      = csr_old_q;
  assign csr_old_vld  = csr_old_vld_q;
  assign redirect_vld = redirect_vld_q;
  assign redirect_pc  = redirect_pc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: expected pulses are queued at issue and matched by a monitor.
module tb_trap_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [1:0]  wb_op = '0;
  logic [31:0] wb_pc = '0;
  logic [11:0] wb_csr_addr = '0;
  logic [1:0]  wb_csr_fn = '0;
  logic [31:0] wb_csr_src = '0;
  logic [31:0] csrs = '0;
  logic [31:0] mepc_in = '0;
  logic [31:0] mtvec_in = '0;
  logic [31:0] csr_addr;
  logic [3:0]  csr_wen;
  logic [31:0] csrd;
  logic        ecall_flag;
  logic [31:0] trap_pc;
  logic [31:0] csr_old;
  logic        csr_old_vld;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        busy;
`ifdef TRAP_SEQ_CNT_EN
  logic [31:0] trap_cnt;
  logic [31:0] exp_cnt = '0;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          kind;  // 0 csr, 1 ecall, 2 redirect
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [3:0]  wen;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  trap_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_op        (wb_op),
    .wb_pc        (wb_pc),
    .wb_csr_addr  (wb_csr_addr),
    .wb_csr_fn    (wb_csr_fn),
    .wb_csr_src   (wb_csr_src),
    .csrs         (csrs),
    .mepc_in      (mepc_in),
    .mtvec_in     (mtvec_in),
    .csr_addr     (csr_addr),
    .csr_wen      (csr_wen),
    .csrd         (csrd),
    .ecall_flag   (ecall_flag),
    .trap_pc      (trap_pc),
    .csr_old      (csr_old),
    .csr_old_vld  (csr_old_vld),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
`ifdef TRAP_SEQ_CNT_EN
    .trap_cnt     (trap_cnt),
`endif
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset) begin
      if (csr_old_vld || ecall_flag || redirect_vld) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got pulse vld=%b ecall=%b redir=%b, required none",
                   csr_old_vld, ecall_flag, redirect_vld);
        end else begin
          e = sb.pop_front();
          if (e.kind == 0) begin
            if (!(csr_old_vld && csrd === e.a && csr_old === e.b && csr_addr === e.c &&
                  csr_wen === e.wen)) begin
              errors++;
              $display("FAIL sb_csr: got vld=%b csrd=%h old=%h addr=%h wen=%b, required csrd=%h old=%h addr=%h wen=%b",
                       csr_old_vld, csrd, csr_old, csr_addr, csr_wen, e.a, e.b, e.c, e.wen);
            end
          end else if (e.kind == 1) begin
            if (!(ecall_flag && csrd === e.a && trap_pc === e.b && csr_wen === e.wen)) begin
              errors++;
              $display("FAIL sb_ecall: got flag=%b csrd=%h trap_pc=%h wen=%b, required csrd=%h trap_pc=%h wen=%b",
                       ecall_flag, csrd, trap_pc, csr_wen, e.a, e.b, e.wen);
            end
          end else begin
            if (!(redirect_vld && redirect_pc === e.a)) begin
              errors++;
              $display("FAIL sb_redirect: got vld=%b pc=%h, required vld=1 pc=%h",
                       redirect_vld, redirect_pc, e.a);
            end
          end
        end
      end
      if (csr_wen !== 4'b0000 && !csr_old_vld && !ecall_flag) begin
        checks++;
        errors++;
        $display("FAIL stray_wen: got csr_wen=%b outside a write pulse, required 0000", csr_wen);
      end
    end
  end

  function automatic void csr_model(input logic [1:0] fn, input logic [11:0] addr,
                                    input logic [31:0] src, input logic [31:0] old,
                                    output logic [31:0] d, output logic [3:0] wen);
    logic [31:0] s;
    s = (fn == 2'd0) ? 32'h0 : src;
    if (fn == 2'd1)      d = s;
    else if (fn == 2'd3) d = old & ~s;
    else                 d = old | s;
    if      (addr == 12'h341) wen = 4'b0001;
    else if (addr == 12'h342) wen = 4'b0010;
    else if (addr == 12'h300) wen = 4'b0100;
    else if (addr == 12'h305) wen = 4'b1000;
    else                      wen = 4'b0000;
    if (fn != 2'd1 && s == 32'h0) wen = 4'b0000;
  endfunction

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [3:0] wen);
    exp_t x;
    x.kind = kind; x.a = a; x.b = b; x.c = c; x.wen = wen;
    sb.push_back(x);
  endtask

  // Called at a negedge with the DUT idle; returns 1 ns after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] pc, input logic [11:0] addr,
                       input logic [1:0] fn, input logic [31:0] src);
    wb_valid = 1'b1; wb_op = op; wb_pc = pc; wb_csr_addr = addr; wb_csr_fn = fn;
    wb_csr_src = src;
    checks++;
    if (wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: got wb_ready=%b, required 1", wb_ready);
    end
    @(posedge clock);
    #1 wb_valid = 1'b0;
`ifdef TRAP_SEQ_CNT_EN
    if (op == 2'd1) exp_cnt = exp_cnt + 1;
`endif
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (wb_ready !== 1'b1 || busy !== 1'b0 || csr_wen !== 4'b0 || csrd !== 32'h0 ||
        csr_addr !== 32'h0 || ecall_flag !== 1'b0 || redirect_vld !== 1'b0 ||
        csr_old_vld !== 1'b0 || redirect_pc !== 32'h0 || trap_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b busy=%b wen=%b csrd=%h addr=%h ecall=%b redir=%b vld=%b, required ready=1 rest 0",
               wb_ready, busy, csr_wen, csrd, csr_addr, ecall_flag, redirect_vld, csr_old_vld);
    end
`ifdef TRAP_SEQ_CNT_EN
    checks++;
    if (trap_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %h, required 0", trap_cnt);
    end
`endif
    @(negedge clock) reset = 1'b1;
  endtask

  task automatic test_csr_rw;
    csrs = 32'h0;
    @(negedge clock);
    push(0, 32'h8000_0100, 32'h0, 32'h305, 4'b1000);
    issue(2'd0, 32'h0, 12'h305, 2'd1, 32'h8000_0100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (busy !== (i < 2) || csr_addr !== ((i < 2) ? 32'h305 : 32'h0)) begin
        errors++;
        $display("FAIL csr_rw_busy[%0d]: got busy=%b addr=%h, required busy=%b addr=%h", i,
                 busy, csr_addr, (i < 2), (i < 2) ? 32'h305 : 32'h0);
      end
    end
  endtask

  task automatic test_csr_rc;
    csrs = 32'h1888;
    @(negedge clock);
    push(0, 32'h1880, 32'h1888, 32'h300, 4'b0100);
    issue(2'd0, 32'h0, 12'h300, 2'd3, 32'h8);
    repeat (3) @(negedge clock);
    push(0, 32'h1888, 32'h1888, 32'h300, 4'b0000);
    issue(2'd0, 32'h0, 12'h300, 2'd3, 32'h0);
    repeat (2) @(negedge clock);
  endtask

  task automatic test_csr_table;
    logic [1:0]  fn_t   [6] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2};
    logic [11:0] addr_t [6] = '{12'h341, 12'h342, 12'hF11, 12'hF12, 12'h7C0, 12'h305};
    logic [31:0] src_t  [6] = '{32'h3, 32'h5, 32'h1234, 32'h1, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] old_t  [6] = '{32'h10, 32'h77, 32'hABC, 32'h0, 32'h55, 32'h9};
    logic [31:0] d;
    logic [3:0]  w;
    for (int i = 0; i < 6; i++) begin
      csrs = old_t[i];
      @(negedge clock);
      csr_model(fn_t[i], addr_t[i], src_t[i], old_t[i], d, w);
      push(0, d, old_t[i], {20'h0, addr_t[i]}, w);
      issue(2'd0, 32'h0, addr_t[i], fn_t[i], src_t[i]);
      repeat (2) @(negedge clock);
    end
  endtask

  task automatic test_ecall;
    mtvec_in = 32'h8000_0203;
    @(negedge clock);
    push(1, 32'd11, 32'h8000_0040, 32'h0, 4'b0010);
    push(2, 32'h8000_0200, 32'h0, 32'h0, 4'b0000);
    issue(2'd1, 32'h8000_0040, 12'h0, 2'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (busy !== (i < 2) || wb_ready !== (i >= 2)) begin
        errors++;
        $display("FAIL ecall_busy[%0d]: got busy=%b ready=%b, required busy=%b", i, busy,
                 wb_ready, (i < 2));
      end
    end
`ifdef TRAP_SEQ_CNT_EN
    checks++;
    if (trap_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL ecall_cnt: got %h, required %h", trap_cnt, exp_cnt);
    end
`endif
  endtask

  task automatic test_mret;
    mepc_in = 32'h8000_0044;
    @(negedge clock);
    push(2, 32'h8000_0044, 32'h0, 32'h0, 4'b0000);
    issue(2'd2, 32'h0, 12'h0, 2'd0, 32'h0);
    @(negedge clock);
    checks++;
    if (wb_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mret_stall: got ready=%b busy=%b, required ready=0 busy=1", wb_ready, busy);
    end
    @(negedge clock);
    checks++;
    if (wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL mret_done: got ready=%b, required 1", wb_ready);
    end
  endtask

  task automatic test_reserved_op;
    @(negedge clock);
    issue(2'd3, 32'h1234, 12'h305, 2'd1, 32'hFFFF);
    @(negedge clock);
    checks++;
    if (wb_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reserved_op: got ready=%b busy=%b, required ready=1 busy=0", wb_ready, busy);
    end
  endtask

  task automatic test_back_to_back;
    csrs = 32'h10;
    mepc_in = 32'h8000_0100;
    @(negedge clock);
    push(0, 32'h2, 32'h10, 32'h342, 4'b0010);
    issue(2'd0, 32'h0, 12'h342, 2'd1, 32'h2);
    repeat (3) @(negedge clock);
    push(2, 32'h8000_0100, 32'h0, 32'h0, 4'b0000);
    issue(2'd2, 32'h0, 12'h0, 2'd0, 32'h0);
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_mret_busy: got busy=%b, required 1", busy);
    end
    @(negedge clock);
    push(1, 32'd11, 32'h8000_0300, 32'h0, 4'b0010);
    push(2, 32'h8000_0200, 32'h0, 32'h0, 4'b0000);
    issue(2'd1, 32'h8000_0300, 12'h0, 2'd0, 32'h0);
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_mid;
    csrs = 32'h0;
    @(negedge clock);
    issue(2'd0, 32'h0, 12'h305, 2'd1, 32'hDEAD_0000);
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got busy=%b, required 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (wb_ready !== 1'b1 || busy !== 1'b0 || csr_addr !== 32'h0 || csr_wen !== 4'b0 ||
        csrd !== 32'h0 || csr_old_vld !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got ready=%b busy=%b addr=%h wen=%b csrd=%h vld=%b, required ready=1 rest 0",
               wb_ready, busy, csr_addr, csr_wen, csrd, csr_old_vld);
    end
`ifdef TRAP_SEQ_CNT_EN
    exp_cnt = '0;
`endif
    @(negedge clock) reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (csr_wen !== 4'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_after[%0d]: got wen=%b busy=%b, required wen=0 busy=0", i, csr_wen,
                 busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_csr_rw();
    test_csr_rc();
    test_csr_table();
    test_ecall();
    test_mret();
    test_reserved_op();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expectations, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
